// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants.
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam int ADDR_W = 32;
    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with pointer/count flush.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset; readers gate on count.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch front end: PC, fetch buffer, redirect handling.
// Optional perf counters enabled by defining IFETCH_PERF_EN.
module ins_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [ADDR_W-1:0] r_pc;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic [CW-1:0]     w_count;
    fetch_entry_t      w_wentry;
    fetch_entry_t      w_rentry;

    assign w_pop  = if_valid & if_ready;
    assign w_push = fetch_en & ~redirect_valid & (~w_full | w_pop);
    assign w_wentry = '{pc: r_pc, instr: imem_instr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VEC;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + PC_INC;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_wdata (w_wentry),
        .o_rdata (w_rentry),
        .o_count (w_count),
        .o_full  (w_full)
    );

    assign imem_addr = r_pc;
    assign if_valid  = (w_count != '0);
    assign if_pc     = if_valid ? w_rentry.pc : '0;
    assign if_instr  = if_valid ? w_rentry.instr : NOP_INSTR;

`ifdef IFETCH_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (if_valid && !if_ready && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (redirect_valid && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif
endmodule

// File: tb/tb_ins_fetch.sv
// Directed vector bench for ins_fetch with a two-word ROM model.
module tb_ins_fetch;
    localparam logic [31:0] IA = 32'h2000_0001;
    localparam logic [31:0] IJ = 32'h0800_0000;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    ins_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        imem_instr = 32'h0;
        if (imem_addr == 32'h0) imem_instr = IA;
        else if (imem_addr == 32'h4) imem_instr = IJ;
    end

    typedef struct {
        bit          rst;
        bit          fe;
        bit          rdy;
        bit          red;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
    } vec_t;

    vec_t vq[$];
    int   n_vec;
    int   n_bad;
    int   stall_exp;
    int   flush_exp;

    task automatic add(input bit rst, input bit fe, input bit rdy,
                       input bit red, input logic [31:0] rpc,
                       input logic [31:0] addr, input logic v,
                       input logic [31:0] pc, input logic [31:0] ins);
        vec_t e;
        e.rst = rst; e.fe = fe; e.rdy = rdy; e.red = red; e.rpc = rpc;
        e.addr = addr; e.v = v; e.pc = pc; e.ins = ins;
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, act, exp);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0; stall_exp = 0; flush_exp = 0;
        rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;

        // straight-line fetch from reset
        add(1,1,1,0,0,          32'h0,1'b0,32'h0,32'h0);
        add(0,1,1,0,0,          32'h4,1'b1,32'h0,IA);
        add(0,1,1,0,0,          32'h8,1'b1,32'h4,IJ);
        add(0,1,1,0,0,          32'hC,1'b1,32'h8,32'h0);
        // stall fills buffer, then drain without gaps
        add(1,1,0,0,0,          32'h0,1'b0,32'h0,32'h0);
        add(0,1,0,0,0,          32'h4,1'b1,32'h0,IA);
        add(0,1,0,0,0,          32'h8,1'b1,32'h0,IA);
        add(0,1,0,0,0,          32'h8,1'b1,32'h0,IA);
        add(0,1,0,0,0,          32'h8,1'b1,32'h0,IA);
        add(0,1,1,0,0,          32'h8,1'b1,32'h0,IA);
        // redirect to 0 while pc 4 is accepted
        add(0,1,1,1,32'h0,      32'hC,1'b1,32'h4,IJ);
        add(0,1,1,0,0,          32'h0,1'b0,32'h0,32'h0);
        add(0,1,1,0,0,          32'h4,1'b1,32'h0,IA);
        // redirect to misaligned 7 -> 4
        add(0,1,1,1,32'h7,      32'h8,1'b1,32'h4,IJ);
        add(0,1,1,0,0,          32'h4,1'b0,32'h0,32'h0);
        add(0,1,1,0,0,          32'h8,1'b1,32'h4,IJ);
        // wrap at top of address space
        add(0,1,1,1,32'hFFFF_FFF8, 32'hC,1'b1,32'h8,32'h0);
        add(0,1,1,0,0,          32'hFFFF_FFF8,1'b0,32'h0,32'h0);
        add(0,1,1,0,0,          32'hFFFF_FFFC,1'b1,32'hFFFF_FFF8,32'h0);
        add(0,1,1,0,0,          32'h0,1'b1,32'hFFFF_FFFC,32'h0);
        add(0,1,1,0,0,          32'h4,1'b1,32'h0,IA);
        // redirect while fetch disabled, then refill to full
        add(0,0,0,1,32'h4,      32'h8,1'b1,32'h4,IJ);
        add(0,0,1,0,0,          32'h4,1'b0,32'h0,32'h0);
        add(0,1,0,0,0,          32'h4,1'b0,32'h0,32'h0);
        add(0,1,0,0,0,          32'h8,1'b1,32'h4,IJ);
        add(0,1,0,0,0,          32'hC,1'b1,32'h4,IJ);
        add(0,1,0,0,0,          32'hC,1'b1,32'h4,IJ);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (vq[i].rst) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
                stall_exp = 0;
                flush_exp = 0;
            end
            fetch_en       = vq[i].fe;
            if_ready       = vq[i].rdy;
            redirect_valid = vq[i].red;
            redirect_pc    = vq[i].rpc;
            #1;
            chk("imem_addr", i, imem_addr, vq[i].addr);
            chk("if_valid",  i, {31'b0, if_valid}, {31'b0, vq[i].v});
            chk("if_pc",     i, if_pc, vq[i].pc);
            chk("if_instr",  i, if_instr, vq[i].ins);
            if (vq[i].v && !vq[i].rdy) stall_exp++;
            if (vq[i].red) flush_exp++;
        end

        // asynchronous reset while full and stalled
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef IFETCH_PERF_EN
        chk("perf_stall", 0, perf_stall_cnt, 32'(stall_exp));
        chk("perf_flush", 0, {16'b0, perf_flush_cnt}, 32'(flush_exp));
`endif
        chk("pre_rst_valid", 0, {31'b0, if_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 0, {31'b0, if_valid}, 32'h0);
        chk("rst_addr",  0, imem_addr, 32'h0);
        chk("rst_pc",    0, if_pc, 32'h0);
        chk("rst_instr", 0, if_instr, 32'h0);
`ifdef IFETCH_PERF_EN
        chk("rst_perf_stall", 0, perf_stall_cnt, 32'h0);
        chk("rst_perf_flush", 0, {16'b0, perf_flush_cnt}, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_addr",  0, imem_addr, 32'h4);
        chk("post_rst_valid", 0, {31'b0, if_valid}, 32'h1);
        chk("post_rst_pc",    0, if_pc, 32'h0);
        chk("post_rst_instr", 0, if_instr, IA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
